// File: rtl/loader_pkg.sv
// Shared types and constants for the serial program loader.
// The CHECK state exists only when LOADER_CHECKSUM_EN is defined.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        HI,
        LO
`ifdef LOADER_CHECKSUM_EN
        ,
        CHECK
`endif
    } loader_state_t;

    localparam logic [7:0] START_BYTE = 8'h55;

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte watchdog: counts idle cycles while enabled and flags expiry
// once TIMEOUT_CYCLES cycles pass without a kick.
module loader_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic kick,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!enable || kick) begin
            cnt <= '0;
        end else if (!expired) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Fires on the TIMEOUT_CYCLES-th silent cycle so the FSM leaves on that edge.
    assign expired = enable && !kick && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/program_loader.sv
// Byte-stream program loader: 0x55, count, then HI/LO pairs written to program memory.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  program_write,
    output logic [ADDR_WIDTH-1:0] program_addr,
    output logic [DATA_WIDTH-1:0] program_cmd,
    output logic                  core_halt,
    output logic                  load_done,
    output logic                  load_error
);

    loader_state_t         state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [ADDR_WIDTH-1:0] n, n_nxt;
    logic [3:0]            hi_nib, hi_nib_nxt;
    logic [DATA_WIDTH-1:0] cmd_nxt;
    logic                  wr_nxt;
    logic                  done_nxt;
    logic                  err_nxt;
    logic                  expired;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            chk, chk_nxt;
`endif

    loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .enable (state != IDLE),
        .kick   (rx_valid),
        .expired(expired)
    );

    // Halt stays high through the final write, whose cycle is already spent in IDLE.
    assign core_halt = (state != IDLE) || program_write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            program_addr  <= '0;
            program_cmd   <= '0;
            program_write <= 1'b0;
            load_done     <= 1'b0;
            load_error    <= 1'b0;
            n             <= '0;
            hi_nib        <= '0;
`ifdef LOADER_CHECKSUM_EN
            chk           <= '0;
`endif
        end else begin
            state         <= state_nxt;
            program_addr  <= addr_nxt;
            program_cmd   <= cmd_nxt;
            program_write <= wr_nxt;
            load_done     <= done_nxt;
            load_error    <= err_nxt;
            n             <= n_nxt;
            hi_nib        <= hi_nib_nxt;
`ifdef LOADER_CHECKSUM_EN
            chk           <= chk_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt  = state;
        addr_nxt   = program_addr;
        n_nxt      = n;
        hi_nib_nxt = hi_nib;
        cmd_nxt    = program_cmd;
        wr_nxt     = 1'b0;
        done_nxt   = 1'b0;
        err_nxt    = load_error;
`ifdef LOADER_CHECKSUM_EN
        chk_nxt    = chk;
`endif

        // Address advances once the write pulse has been presented.
        if (program_write) begin
            addr_nxt = program_addr + ADDR_WIDTH'(1);
        end

        if (expired) begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
        end else if (rx_valid) begin
            case (state)
                IDLE: begin
                    if (rx_data == START_BYTE) begin
                        state_nxt = COUNT;
                        err_nxt   = 1'b0;
                        addr_nxt  = '0;
                        n_nxt     = '0;
`ifdef LOADER_CHECKSUM_EN
                        chk_nxt   = '0;
`endif
                    end
                end
                COUNT: begin
                    // Zero wraps through the decrement, giving 2^ADDR_WIDTH writes.
                    n_nxt     = ADDR_WIDTH'(rx_data);
                    state_nxt = HI;
                end
                HI: begin
                    hi_nib_nxt = rx_data[3:0];
`ifdef LOADER_CHECKSUM_EN
                    chk_nxt    = chk ^ rx_data;
`endif
                    state_nxt  = LO;
                end
                LO: begin
                    cmd_nxt = DATA_WIDTH'({hi_nib, rx_data});
                    wr_nxt  = 1'b1;
                    n_nxt   = n - ADDR_WIDTH'(1);
`ifdef LOADER_CHECKSUM_EN
                    chk_nxt = chk ^ rx_data;
`endif
                    if (n == ADDR_WIDTH'(1)) begin
`ifdef LOADER_CHECKSUM_EN
                        state_nxt = CHECK;
`else
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
`endif
                    end else begin
                        state_nxt = HI;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHECK: begin
                    if (rx_data == chk) begin
                        done_nxt = 1'b1;
                    end else begin
                        err_nxt  = 1'b1;
                    end
                    state_nxt = IDLE;
                end
`endif
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus queues expected writes, a monitor pops them.
// Builds with or without LOADER_CHECKSUM_EN.
module tb_program_loader;

    localparam int TMO = 20;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        program_write;
    logic [7:0]  program_addr;
    logic [11:0] program_cmd;
    logic        core_halt;
    logic        load_done;
    logic        load_error;

    typedef struct {
        logic [7:0]  addr;
        logic [11:0] cmd;
        logic        done;
    } wr_t;

    wr_t exp_q[$];
    int  passed = 0;
    int  total  = 0;

    program_loader #(
        .ADDR_WIDTH    (8),
        .DATA_WIDTH    (12),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .program_write(program_write),
        .program_addr (program_addr),
        .program_cmd  (program_cmd),
        .core_halt    (core_halt),
        .load_done    (load_done),
        .load_error   (load_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; presents the byte for exactly one cycle.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic push(input logic [7:0] a, input logic [11:0] c, input logic d);
        wr_t e;
        e.addr = a;
        e.cmd  = c;
        e.done = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every write must match the head of the expected queue.
    always @(negedge clk) begin
        if (program_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_write: got addr %0h cmd %0h, required no write",
                         program_addr, program_cmd);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", program_addr, e.addr);
                check("wr_cmd", program_cmd, e.cmd);
                check("wr_done", load_done, e.done);
            end
        end else if (!CHK_EN && load_done === 1'b1) begin
            total++;
            $display("FAIL stray_done: got load_done 1 without write, required 0");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] lo;

        // Reset state
        tick();
        tick();
        @(negedge clk);
        check("rst_write", program_write, 0);
        check("rst_addr", program_addr, 0);
        check("rst_cmd", program_cmd, 0);
        check("rst_halt", core_halt, 0);
        check("rst_done", load_done, 0);
        check("rst_error", load_error, 0);
        tick();
        reset = 1'b0;
        tick();

        // Junk before header is ignored
        send_byte(8'h12);
        send_byte(8'hAA);
        @(negedge clk);
        check("junk_halt", core_halt, 0);
        check("junk_addr", program_addr, 0);
        tick();

        // Two-instruction load
        push(8'h00, 12'hA3F, 1'b0);
        push(8'h01, 12'h180, !CHK_EN);
        send_byte(8'h55);
        @(negedge clk);
        check("hdr_halt", core_halt, 1);
        tick();
        send_byte(8'h02);
        send_byte(8'h0A);
        send_byte(8'h3F);
        send_byte(8'h01);
        send_byte(8'h80);
        if (CHK_EN) begin
            send_byte(8'hB4);
            @(negedge clk);
            check("two_done_chk", load_done, 1);
        end else begin
            @(negedge clk);
            check("two_halt_last_write", core_halt, 1);
        end
        tick();
        @(negedge clk);
        check("two_halt_after", core_halt, 0);
        check("two_done_after", load_done, 0);
        check("two_addr_after", program_addr, 2);
        check("two_error", load_error, 0);
        tick();

        // Count 0 means 256 writes; HI upper nibble must be dropped
        send_byte(8'h55);
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            lo = ~8'(i);
            push(8'(i), {4'(i), lo}, (i == 255) && !CHK_EN);
            send_byte(8'(i));
            send_byte(lo);
        end
        if (CHK_EN) begin
            send_byte(8'h00);
            @(negedge clk);
            check("full_done_chk", load_done, 1);
        end
        tick();
        @(negedge clk);
        check("full_addr_wrap", program_addr, 0);
        check("full_halt", core_halt, 0);
        tick();

        // Timeout after HI byte
        send_byte(8'h55);
        send_byte(8'h01);
        send_byte(8'h0A);
        repeat (TMO - 1) tick();
        @(negedge clk);
        check("tmo_not_yet_err", load_error, 0);
        check("tmo_not_yet_halt", core_halt, 1);
        tick();
        @(negedge clk);
        check("tmo_error", load_error, 1);
        check("tmo_halt", core_halt, 0);
        check("tmo_done", load_done, 0);
        repeat (5) tick();
        @(negedge clk);
        check("tmo_sticky", load_error, 1);
        tick();

        // Header clears error; reset between HI and LO aborts
        send_byte(8'h55);
        @(negedge clk);
        check("hdr_clears_err", load_error, 0);
        tick();
        send_byte(8'h01);
        send_byte(8'h0A);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_write", program_write, 0);
        check("rst_mid_halt", core_halt, 0);
        check("rst_mid_addr", program_addr, 0);
        check("rst_mid_cmd", program_cmd, 0);
        tick();
        rx_valid = 1'b1;
        rx_data  = 8'hCD;
        tick();
        rx_valid = 1'b0;
        reset = 1'b0;
        tick();
        push(8'h00, 12'hBCD, !CHK_EN);
        send_byte(8'h55);
        send_byte(8'h01);
        send_byte(8'h0B);
        send_byte(8'hCD);
        if (CHK_EN) begin
            send_byte(8'hC6);
            @(negedge clk);
            check("clean_done_chk", load_done, 1);
            tick();
        end
        tick();

`ifdef LOADER_CHECKSUM_EN
        // Checksum match and mismatch
        push(8'h00, 12'hA3F, 1'b0);
        send_byte(8'h55);
        send_byte(8'h01);
        send_byte(8'h0A);
        send_byte(8'h3F);
        send_byte(8'h35);
        @(negedge clk);
        check("cks_ok_done", load_done, 1);
        check("cks_ok_err", load_error, 0);
        tick();
        push(8'h00, 12'hA3F, 1'b0);
        send_byte(8'h55);
        send_byte(8'h01);
        send_byte(8'h0A);
        send_byte(8'h3F);
        send_byte(8'h00);
        @(negedge clk);
        check("cks_bad_done", load_done, 0);
        check("cks_bad_err", load_error, 1);
        tick();
`endif

        repeat (4) tick();
        check("scoreboard_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
